ec_parity_accum_engine: RTL and testbench



---
 rtl/ec_pkg.sv | 22 ++
 rtl/gf_bitmatrix_mult.sv | 20 ++
 rtl/ec_parity_accum_engine.sv | 120 ++++++++++++
 tb/tb_ec_parity_accum_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// Shared types and GF(2) helpers for the erasure-coding parity accumulator.
// Symbols up to GF_MAX_W bits are supported by the helper functions.
package ec_pkg;

   localparam int GF_MAX_W = 32;

   typedef enum logic {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } ec_state_e;

   // Base bit of column i in a flattened W x W bitmatrix.
   function automatic int col_lo(input int i, input int w);
      return i * w;
   endfunction

   // GF(2) dot product: AND then XOR-reduce, no carries.
   function automatic logic gf2_dot(input logic [GF_MAX_W-1:0] a, input logic [GF_MAX_W-1:0] b);
      return ^(a & b);
   endfunction

endpackage

// File: rtl/gf_bitmatrix_mult.sv
// Combinational W x W bitmatrix multiply over GF(2): one dot product per column.
module gf_bitmatrix_mult
   import ec_pkg::*;
#(
   parameter int W = 3
) (
   input  logic [W-1:0]   data_word,
   input  logic [W*W-1:0] bitmatrix_cols,
   output logic [W-1:0]   prod
);

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_col
         assign prod[gi] = gf2_dot(GF_MAX_W'(data_word),
                                   GF_MAX_W'(bitmatrix_cols[col_lo(gi, W) +: W]));
      end
   endgenerate

endmodule

// File: rtl/ec_parity_accum_engine.sv
// Stripe parity accumulator: XORs K bitmatrix products into one parity word.
// Optional statistics counters are enabled with `define EC_ACC_STATS_EN.
module ec_parity_accum_engine
   import ec_pkg::*;
#(
   parameter  int W     = 3,
   parameter  int K     = 4,
   localparam int CNT_W = $clog2(K + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic [W-1:0]     data_word,
   input  logic [W*W-1:0]   bitmatrix_cols,
   output logic             parity_valid,
   input  logic             parity_ready,
   output logic [W-1:0]     parity_word,
   output logic [CNT_W-1:0] word_cnt
`ifdef EC_ACC_STATS_EN
   ,
   output logic [31:0]      stripe_cnt,
   output logic [31:0]      stall_cnt
`endif
);

   ec_state_e        state_reg;
   logic [W-1:0]     acc_reg;
   logic [W-1:0]     parity_word_reg;
   logic             parity_valid_reg;
   logic [CNT_W-1:0] word_cnt_reg;

   logic [W-1:0]     prod;
   logic [W-1:0]     acc_next;
   logic             accept;
   logic             last_word;

   gf_bitmatrix_mult #(.W(W)) u_mult (
      .data_word      (data_word),
      .bitmatrix_cols (bitmatrix_cols),
      .prod           (prod)
   );

   // Handing off the parity frees the slot in the same cycle, so ready
   // follows parity_ready combinationally while a parity is pending.
   assign data_ready = (state_reg == ACCUM) || ((state_reg == OUTPUT) && parity_ready);
   assign accept     = data_valid && data_ready;
   assign last_word  = (word_cnt_reg == CNT_W'(K - 1));
   assign acc_next   = (word_cnt_reg == '0) ? prod : (acc_reg ^ prod);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= ACCUM;
         acc_reg          <= '0;
         parity_word_reg  <= '0;
         parity_valid_reg <= 1'b0;
         word_cnt_reg     <= '0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (accept) begin
                  acc_reg <= acc_next;
                  if (last_word) begin
                     parity_word_reg  <= acc_next;
                     parity_valid_reg <= 1'b1;
                     word_cnt_reg     <= '0;
                     state_reg        <= OUTPUT;
                  end else begin
                     word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                  end
               end
            end
            OUTPUT: begin
               if (parity_ready) begin
                  if (accept && (K == 1)) begin
                     // Single-word stripes complete immediately; stay presenting.
                     parity_word_reg <= prod;
                  end else begin
                     if (accept) begin
                        acc_reg      <= prod;
                        word_cnt_reg <= CNT_W'(1);
                     end
                     parity_valid_reg <= 1'b0;
                     state_reg        <= ACCUM;
                  end
               end
            end
            default: begin
               state_reg        <= ACCUM;
               parity_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign parity_valid = parity_valid_reg;
   assign parity_word  = parity_word_reg;
   assign word_cnt     = word_cnt_reg;

`ifdef EC_ACC_STATS_EN
   logic [31:0] stripe_cnt_reg;
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stripe_cnt_reg <= '0;
         stall_cnt_reg  <= '0;
      end else begin
         if (parity_valid_reg && parity_ready)
            stripe_cnt_reg <= stripe_cnt_reg + 32'd1;
         if (parity_valid_reg && !parity_ready && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stripe_cnt = stripe_cnt_reg;
   assign stall_cnt  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ec_parity_accum_engine.sv
// Randomized + directed bench for ec_parity_accum_engine (W=3, K=2 and K=1 side by side)
// against a stripe-level queue model. Define EC_ACC_STATS_EN to also check the counters.
module tb_ec_parity_accum_engine;

   localparam logic [8:0] ID_COLS   = 9'b100_010_001;
   localparam logic [8:0] ONES_COLS = 9'b111_111_111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_valid = 1'b0;
   logic [2:0] data_word = '0;
   logic [8:0] bitmatrix_cols = '0;
   logic       parity_ready = 1'b0;

   logic [1:0]      dr, pv;
   logic [1:0][2:0] pw;
   logic [1:0]      wc0;
   logic [0:0]      wc1;
`ifdef EC_ACC_STATS_EN
   logic [1:0][31:0] sc, stc;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Model state: index 0 models the K=2 instance, index 1 the K=1 instance.
   int          kk [2] = '{2, 1};
   logic [2:0]  mq [2][$];
   logic        mfull [2];
   logic [2:0]  mword [2];
   int unsigned mstripes [2];
   int unsigned mstalls [2];

   always #5 clk = ~clk;

   ec_parity_accum_engine #(.W(3), .K(2)) u_dut_k2 (
      .clk            (clk),
      .rst            (rst),
      .data_valid     (data_valid),
      .data_ready     (dr[0]),
      .data_word      (data_word),
      .bitmatrix_cols (bitmatrix_cols),
      .parity_valid   (pv[0]),
      .parity_ready   (parity_ready),
      .parity_word    (pw[0]),
      .word_cnt       (wc0)
`ifdef EC_ACC_STATS_EN
      ,
      .stripe_cnt     (sc[0]),
      .stall_cnt      (stc[0])
`endif
   );

   ec_parity_accum_engine #(.W(3), .K(1)) u_dut_k1 (
      .clk            (clk),
      .rst            (rst),
      .data_valid     (data_valid),
      .data_ready     (dr[1]),
      .data_word      (data_word),
      .bitmatrix_cols (bitmatrix_cols),
      .parity_valid   (pv[1]),
      .parity_ready   (parity_ready),
      .parity_word    (pw[1]),
      .word_cnt       (wc1)
`ifdef EC_ACC_STATS_EN
      ,
      .stripe_cnt     (sc[1]),
      .stall_cnt      (stc[1])
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Matrix-vector product from its definition: bit i is the parity of popcount(d & col_i).
   function automatic logic [2:0] mprod(input logic [2:0] d, input logic [8:0] c);
      logic [2:0] r;
      for (int i = 0; i < 3; i++)
         r[i] = ($countones(d & c[i*3 +: 3]) % 2) == 1;
      return r;
   endfunction

   // One clock cycle: drive at negedge, compare, then advance the model at posedge.
   task automatic step(input logic dv, input logic [2:0] dw, input logic [8:0] cols,
                       input logic pr, input logic rs);
      logic       er;
      logic [2:0] x;
      @(negedge clk);
      data_valid     = dv;
      data_word      = dw;
      bitmatrix_cols = cols;
      parity_ready   = pr;
      rst            = rs;
      #1;
      if (!rs) begin
         for (int m = 0; m < 2; m++) begin
            er = !mfull[m] || pr;
            check($sformatf("k%0d_ready", kk[m]), 32'(dr[m]), 32'(er));
            check($sformatf("k%0d_valid", kk[m]), 32'(pv[m]), 32'(mfull[m]));
            if (mfull[m])
               check($sformatf("k%0d_parity", kk[m]), 32'(pw[m]), 32'(mword[m]));
            check($sformatf("k%0d_word_cnt", kk[m]),
                  (m == 0) ? 32'(wc0) : 32'(wc1), 32'(mq[m].size()));
`ifdef EC_ACC_STATS_EN
            check($sformatf("k%0d_stripe_cnt", kk[m]), sc[m], mstripes[m]);
            check($sformatf("k%0d_stall_cnt", kk[m]), stc[m], mstalls[m]);
`endif
         end
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (rs) begin
            mq[m].delete();
            mfull[m]    = 1'b0;
            mword[m]    = '0;
            mstripes[m] = 0;
            mstalls[m]  = 0;
         end else begin
            er = !mfull[m] || pr;
            if (mfull[m] && pr) begin
               mstripes[m]++;
               mfull[m] = 1'b0;
            end else if (mfull[m] && mstalls[m] != 32'hFFFF_FFFF) begin
               mstalls[m]++;
            end
            if (dv && er) begin
               mq[m].push_back(mprod(dw, cols));
               if (mq[m].size() == kk[m]) begin
                  x = '0;
                  foreach (mq[m][j]) x ^= mq[m][j];
                  mword[m] = x;
                  mfull[m] = 1'b1;
                  mq[m].delete();
               end
            end
         end
      end
   endtask

   task automatic idle(input logic pr);
      step(1'b0, 3'b000, 9'd0, pr, 1'b0);
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         mfull[m] = 1'b0; mword[m] = '0; mstripes[m] = 0; mstalls[m] = 0;
      end

      // Reset state
      step(1'b0, 3'b000, 9'd0, 1'b0, 1'b1);
      step(1'b0, 3'b000, 9'd0, 1'b0, 1'b1);
      #2;
      check("rst_valid", 32'(pv), 32'd0);
      check("rst_parity", 32'(pw), 32'd0);
      check("rst_word_cnt", 32'({wc0, wc1}), 32'd0);
`ifdef EC_ACC_STATS_EN
      check("rst_stats", sc[0] | stc[0] | sc[1] | stc[1], 32'd0);
`endif

      // Basic stripe: 101*identity ^ 001*ones = 101 ^ 111 = 010
      step(1'b1, 3'b101, ID_COLS, 1'b1, 1'b0);
      step(1'b1, 3'b001, ONES_COLS, 1'b1, 1'b0);
      #2;
      check("basic_valid", 32'(pv[0]), 32'd1);
      check("basic_parity", 32'(pw[0]), 32'b010);
      check("basic_word_cnt", 32'(wc0), 32'd0);
      idle(1'b1);

      // Backpressure, then release with the next stripe's first word on the handshake
      step(1'b1, 3'b101, ID_COLS, 1'b1, 1'b0);
      step(1'b1, 3'b001, ONES_COLS, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 3'b011, ID_COLS, 1'b0, 1'b0);
         #2;
         check("bp_parity", 32'(pw[0]), 32'b010);
      end
      step(1'b1, 3'b011, ID_COLS, 1'b1, 1'b0);
      step(1'b1, 3'b011, ONES_COLS, 1'b1, 1'b0);
      #2;
      check("b2b_valid", 32'(pv[0]), 32'd1);
      check("b2b_parity", 32'(pw[0]), 32'b011);
      idle(1'b1);

      // Reset mid-stripe discards the partial word
      step(1'b1, 3'b101, ID_COLS, 1'b1, 1'b0);
      step(1'b0, 3'b000, 9'd0, 1'b1, 1'b1);
      step(1'b1, 3'b101, ID_COLS, 1'b1, 1'b0);
      step(1'b1, 3'b001, ONES_COLS, 1'b1, 1'b0);
      #2;
      check("rst_mid_parity", 32'(pw[0]), 32'b010);

      // K=1: consecutive parities 110 then 000
      step(1'b0, 3'b000, 9'd0, 1'b1, 1'b1);
      step(1'b1, 3'b110, ID_COLS, 1'b1, 1'b0);
      #2;
      check("k1_first", 32'(pw[1]), 32'b110);
      step(1'b1, 3'b110, ONES_COLS, 1'b1, 1'b0);
      #2;
      check("k1_second", 32'(pw[1]), 32'b000);
      check("k1_second_valid", 32'(pv[1]), 32'd1);
      idle(1'b1);

`ifdef EC_ACC_STATS_EN
      // Three stripes with four stall cycles in total
      step(1'b0, 3'b000, 9'd0, 1'b1, 1'b1);
      for (int s = 0; s < 3; s++) begin
         step(1'b1, 3'b101, ID_COLS, 1'b1, 1'b0);
         step(1'b1, 3'b001, ONES_COLS, 1'b1, 1'b0);
         for (int i = 0; i < ((s < 2) ? 2 : 0); i++) idle(1'b0);
         idle(1'b1);
      end
      #2;
      check("stats_stripes", sc[0], 32'd3);
      check("stats_stalls", stc[0], 32'd4);
      step(1'b0, 3'b000, 9'd0, 1'b1, 1'b1);
      #2;
      check("stats_rst", sc[0] | stc[0], 32'd0);
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0, 3'($urandom), 9'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
